// File: rtl/decodificador_multiplexado.sv
// Passive receiver for the multiplexed active-low 7-segment bus.
// Debounces each digit dwell, decodes it and assembles full frames.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   enable       1 = decode, 0 = idle (drops partial frame)
//   segmentos    active-low segments {g,f,e,d,c,b,a}
//   anodos       active-low anodes, one low = digit selected
//   frame        5-bit code per digit, snapshot at frame completion
//   digit_seen   positions committed since the last frame
//   frame_valid  1-cycle pulse, frame updated on the same edge
//   err_multi    1-cycle pulse, stable dwell with >1 anode low
//   err_code     1-cycle pulse, committed pattern not in table
module decodificador_multiplexado #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4,
    parameter logic [NUM_DIGITS-1:0] DIGIT_MASK = 8'b01111100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [6:0]              segmentos,
    input  logic [NUM_DIGITS-1:0]   anodos,
    output logic [5*NUM_DIGITS-1:0] frame,
    output logic [NUM_DIGITS-1:0]   digit_seen,
    output logic                    frame_valid,
    output logic                    err_multi,
    output logic                    err_code
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE =
        {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [5*NUM_DIGITS-1:0] BLANK =
        {NUM_DIGITS{5'd14}};

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] c;
        case (s)
            7'b1000000: c = 5'd0;
            7'b1111001: c = 5'd1;
            7'b0100100: c = 5'd2;
            7'b0110000: c = 5'd3;
            7'b0011001: c = 5'd4;
            7'b0010010: c = 5'd5;
            7'b0000010: c = 5'd6;
            7'b1111000: c = 5'd7;
            7'b0000000: c = 5'd8;
            7'b0010000: c = 5'd9;
            7'b0001000: c = 5'd10;
            7'b0100001: c = 5'd11;
            7'b1100011: c = 5'd12;
            7'b1111011: c = 5'd13;
            7'b1111111: c = 5'd14;
            default:    c = 5'd31;
        endcase
        return c;
    endfunction

    logic [SW-1:0]           smp;
    logic [SW-1:0]           sample;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic                    committed;
    logic [5*NUM_DIGITS-1:0] work;
    logic [5*NUM_DIGITS-1:0] work_nxt;
    logic [NUM_DIGITS-1:0]   seen_nxt;
    logic [NUM_DIGITS-1:0]   sel;
    logic [4:0]              code;
    logic                    changed;
    logic                    commit;
    logic                    one_hot;
    logic                    multi;
    logic                    done;

    // The bus word about to enter smp is compared with smp itself,
    // i.e. the smp/prev comparison seen one edge early, so a pattern
    // first captured at edge E commits at edge E+STABLE_CYCLES-1.
    always_comb begin
        sample   = {anodos, segmentos};
        sel      = ~anodos;
        changed  = sample != smp;
        cnt_nxt  = cnt;
        if (changed)
            cnt_nxt = CW'(1);
        else if (cnt < CMAX)
            cnt_nxt = cnt + CW'(1);
        commit   = !committed && (cnt_nxt == CMAX);
        one_hot  = (sel != '0) && ((sel & (sel - ONE)) == '0);
        multi    = (sel != '0) && !one_hot;
        code     = decode(segmentos);
        work_nxt = work;
        seen_nxt = digit_seen;
        if (commit && one_hot) begin
            seen_nxt = digit_seen | sel;
            for (int k = 0; k < NUM_DIGITS; k++)
                if (sel[k])
                    work_nxt[5*k +: 5] = code;
        end
        done = commit && one_hot &&
               ((seen_nxt & DIGIT_MASK) == DIGIT_MASK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp         <= '0;
            cnt         <= '0;
            committed   <= 1'b0;
            work        <= BLANK;
            frame       <= BLANK;
            digit_seen  <= '0;
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            err_code    <= 1'b0;
        end else begin
            smp         <= sample;
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            err_code    <= 1'b0;
            if (!enable) begin
                cnt        <= '0;
                committed  <= 1'b0;
                digit_seen <= '0;
            end else begin
                cnt       <= cnt_nxt;
                committed <= changed ? 1'b0 : (committed | commit);
                if (commit) begin
                    work      <= work_nxt;
                    err_multi <= multi;
                    err_code  <= one_hot && (code == 5'd31);
                    if (done) begin
                        frame       <= work_nxt;
                        frame_valid <= 1'b1;
                        digit_seen  <= '0;
                    end else begin
                        digit_seen  <= seen_nxt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_decodificador_multiplexado.sv
// Scoreboard bench for decodificador_multiplexado.
// Directed dwells; a monitor pops expected pulses as they appear.
module tb_decodificador_multiplexado;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [6:0]  segmentos;
    logic [7:0]  anodos;
    logic [39:0] frame;
    logic [7:0]  digit_seen;
    logic        frame_valid;
    logic        err_multi;
    logic        err_code;

    decodificador_multiplexado dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .segmentos(segmentos),
        .anodos(anodos),
        .frame(frame),
        .digit_seen(digit_seen),
        .frame_valid(frame_valid),
        .err_multi(err_multi),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic        em;
        logic        ec;
        logic [24:0] f;
    } ev_t;

    ev_t q[$];
    int  n_vec = 0;
    int  n_err = 0;

    logic [6:0] SEG [0:13];
    localparam logic [39:0] FBLANK = {8{5'd14}};
    localparam logic [6:0] BAD = 7'b1010101;

    initial begin
        SEG[0]  = 7'b1000000; SEG[1]  = 7'b1111001;
        SEG[2]  = 7'b0100100; SEG[3]  = 7'b0110000;
        SEG[4]  = 7'b0011001; SEG[5]  = 7'b0010010;
        SEG[6]  = 7'b0000010; SEG[7]  = 7'b1111000;
        SEG[8]  = 7'b0000000; SEG[9]  = 7'b0010000;
        SEG[10] = 7'b0001000; SEG[11] = 7'b0100001;
        SEG[12] = 7'b1100011; SEG[13] = 7'b1111011;
    end

    // Monitor: every pulse must match the next queued expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1 || err_multi === 1'b1 ||
                err_code === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse got fv=%b em=%b ec=%b",
                             frame_valid, err_multi, err_code);
                end else begin
                    e = q.pop_front();
                    if ({frame_valid, err_multi, err_code} !==
                            {e.fv, e.em, e.ec} ||
                        (e.fv && frame[34:10] !== e.f)) begin
                        n_err++;
                        $display("FAIL pulse got fv=%b em=%b ec=%b f=%h need fv=%b em=%b ec=%b f=%h",
                                 frame_valid, err_multi, err_code,
                                 frame[34:10], e.fv, e.em, e.ec, e.f);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [39:0] got,
                         input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h need %h", name, got, exp);
        end
    endtask

    task automatic push(input logic fv, input logic em, input logic ec,
                        input logic [24:0] f);
        ev_t e;
        e.fv = fv; e.em = em; e.ec = ec; e.f = f;
        q.push_back(e);
    endtask

    task automatic dwell(input int k, input logic [6:0] s, input int n);
        anodos    = ~(8'd1 << k);
        segmentos = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        anodos    = 8'hFF;
        segmentos = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [24:0] f5(input int a, input int b,
            input int c, input int d, input int e);
        return {a[4:0], b[4:0], c[4:0], d[4:0], e[4:0]};
    endfunction

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        anodos    = 8'hFF;
        segmentos = 7'h7F;
        repeat (2) @(negedge clk);
        check("reset_frame", frame, FBLANK);
        check("reset_seen", 40'(digit_seen), 40'h0);
        check("reset_pulses", 40'({frame_valid, err_multi, err_code}),
              40'h0);
        rst_n = 1'b1;

        blank(2);
        dwell(5, SEG[10], 3);
        check("short_dwell", 40'(digit_seen), 40'h0);
        dwell(6, SEG[11], 4);
        check("single_dwell", 40'(digit_seen), 40'h40);

        blank(2);
        push(1'b1, 1'b0, 1'b0, f5(11, 10, 12, 13, 11));
        dwell(6, SEG[11], 6);
        dwell(5, SEG[10], 6);
        dwell(4, SEG[12], 6);
        dwell(3, SEG[13], 6);
        dwell(2, SEG[11], 6);
        check("scan_seen", 40'(digit_seen), 40'h0);
        check("scan_frame", 40'(frame[34:10]),
              40'(f5(11, 10, 12, 13, 11)));

        blank(2);
        push(1'b0, 1'b1, 1'b0, 25'h0);
        anodos    = 8'b10011111;
        segmentos = SEG[11];
        repeat (4) @(negedge clk);
        check("multi_seen", 40'(digit_seen), 40'h0);

        blank(2);
        push(1'b0, 1'b0, 1'b1, 25'h0);
        dwell(6, BAD, 6);
        check("badcode_seen", 40'(digit_seen), 40'h40);
        dwell(0, SEG[9], 6);
        check("wrap_seen", 40'(digit_seen), 40'h41);
        push(1'b1, 1'b0, 1'b0, f5(31, 1, 2, 3, 4));
        dwell(5, SEG[1], 6);
        dwell(4, SEG[2], 6);
        dwell(3, SEG[3], 6);
        dwell(2, SEG[4], 6);
        check("code31_seen", 40'(digit_seen), 40'h0);

        push(1'b1, 1'b0, 1'b1, f5(5, 6, 7, 8, 31));
        dwell(6, SEG[5], 6);
        dwell(5, SEG[6], 6);
        dwell(4, SEG[7], 6);
        dwell(3, SEG[8], 6);
        dwell(2, BAD, 6);
        check("simul_seen", 40'(digit_seen), 40'h0);

        blank(2);
        dwell(6, SEG[0], 6);
        dwell(5, SEG[1], 6);
        dwell(4, SEG[2], 6);
        check("pre_disable", 40'(digit_seen), 40'h70);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("disabled_seen", 40'(digit_seen), 40'h0);
        enable = 1'b1;
        dwell(3, SEG[3], 6);
        dwell(2, SEG[4], 6);
        check("reenable_seen", 40'(digit_seen), 40'h0C);
        push(1'b1, 1'b0, 1'b0, f5(0, 1, 2, 3, 4));
        dwell(6, SEG[0], 6);
        dwell(5, SEG[1], 6);
        dwell(4, SEG[2], 6);
        check("refill_seen", 40'(digit_seen), 40'h0);

        blank(2);
        dwell(6, SEG[5], 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_seen", 40'(digit_seen), 40'h0);
        check("midreset_frame", frame, FBLANK);
        blank(6);
        check("midreset_late", 40'(digit_seen), 40'h0);

        repeat (4) @(negedge clk);
        check("pending_events", 40'(q.size()), 40'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
